// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 data mux.
// A hold-limit counter caps how long one requester keeps the mux while
// the other is waiting. Grants, select and data are all registered.
module mux2_rr_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_e;

    // Last cycle of a tenure while the other side waits.
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_e           state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;

    // State, hold counter and round-robin pointer; last=1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_cnt_q <= 8'd0;
            last_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
        end
    end

    // Next-state arbitration: direct handoff on release, preemption only at the hold limit.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1)  state_d = last_q ? G0 : G1;
                else if (req0)     state_d = G0;
                else if (req1)     state_d = G1;
            end
            G0: begin
                if (!req0)                            state_d = req1 ? G1 : IDLE;
                else if (req1 && hold_cnt_q == HOLD_LIM) state_d = G1;
            end
            G1: begin
                if (!req1)                            state_d = req0 ? G0 : IDLE;
                else if (req0 && hold_cnt_q == HOLD_LIM) state_d = G0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter clears on any grant change and saturates at the limit while the owner stays.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        if (state_d != state_q || state_d == IDLE) begin
            hold_cnt_d = 8'd0;
        end else if (hold_cnt_q != HOLD_LIM) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
        if (state_d == G0)      last_d = 1'b0;
        else if (state_d == G1) last_d = 1'b1;
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        gnt0 = (state_q == G0);
        gnt1 = (state_q == G1);
        sel  = (state_q == G1);
    end

    // Single registered mux stage; valid only when the granted side is still requesting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_q       <= sel ? i1 : i0;
            y_valid_q <= ((state_q == G0) && req0) || ((state_q == G1) && req1);
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;

endmodule
